adder_result_accumulator: RTL and testbench

Downstream stage for the 4-bit full adder: consumes each `{Cout, Sum}` result as a 5-bit unsigned value over a valid/ready handshake. It accumulates `COUNT_N` consecutive results into a running total, then presents the block total with an overflow flag over a second valid/ready handshake. It turns the combinational adder into a measurable block-sum datapath.

---
 rtl/adder_result_accumulator_if.sv | 27 ++
 rtl/adder_result_accumulator.sv | 91 +++++++++
 tb/tb_adder_result_accumulator.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/adder_result_accumulator_if.sv
// rtl/adder_result_accumulator_if.sv - result/block handshake bundle for adder_result_accumulator
interface adder_result_accumulator_if #(
  parameter int ACC_W   = 8,
  parameter int COUNT_N = 4
);
  localparam int CNT_W = $clog2(COUNT_N + 1);

  logic             In_valid;
  logic             In_ready;
  logic [3:0]       Sum;
  logic             Cout;
  logic             Out_valid;
  logic             Out_ready;
  logic [ACC_W-1:0] Acc;
  logic             Ovf;
  logic [CNT_W-1:0] Count;

  modport master (
    output In_valid, Sum, Cout, Out_ready,
    input  In_ready, Out_valid, Acc, Ovf, Count
  );

  modport slave (
    input  In_valid, Sum, Cout, Out_ready,
    output In_ready, Out_valid, Acc, Ovf, Count
  );
endinterface

// File: rtl/adder_result_accumulator.sv
// rtl/adder_result_accumulator.sv - sums COUNT_N adder results per block, reports total and overflow
// ADD_ACC_SAT_EN: saturate Acc at 2^ACC_W-1 on carry instead of wrapping.
module adder_result_accumulator #(
  parameter int ACC_W   = 8,
  parameter int COUNT_N = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Clear,
  adder_result_accumulator_if.slave bus
);
  localparam int                CNT_W    = $clog2(COUNT_N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT_N);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc_q, acc_nxt, acc_add;
  logic             ovf_q, ovf_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             vld_q;
  logic [ACC_W:0]   sample, sum_w;
  logic             accept;

  assign sample = {{(ACC_W-4){1'b0}}, bus.Cout, bus.Sum};
  // Acc is zero in IDLE, so one adder serves both the first load and later accumulates.
  assign sum_w  = {1'b0, acc_q} + sample;

`ifdef ADD_ACC_SAT_EN
  assign acc_add = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
  assign acc_add = sum_w[ACC_W-1:0];
`endif

  assign bus.In_ready = (state != DONE);
  assign accept       = bus.In_valid && (state != DONE);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_q;
    ovf_nxt   = ovf_q;
    cnt_nxt   = cnt_q;
    unique case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_nxt   = acc_add;
          ovf_nxt   = ovf_q | sum_w[ACC_W];
          cnt_nxt   = cnt_q + CNT_W'(1);
          state_nxt = (cnt_nxt == LAST_CNT) ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (bus.Out_ready) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over any same-cycle accept or output handshake.
    if (Clear) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      ovf_nxt   = 1'b0;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc_q <= acc_nxt;
      ovf_q <= ovf_nxt;
      cnt_q <= cnt_nxt;
      vld_q <= (state_nxt == DONE);
    end
  end

  assign bus.Out_valid = vld_q;
  assign bus.Acc       = acc_q;
  assign bus.Ovf       = ovf_q;
  assign bus.Count     = cnt_q;
endmodule

// File: tb/tb_adder_result_accumulator.sv
// tb/tb_adder_result_accumulator.sv - three configurations driven in lockstep against a block-sum model
module tb_adder_result_accumulator;
  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [4:0] v;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  // Instance 0: ACC_W=8/N=4, 1: ACC_W=5/N=4, 2: ACC_W=8/N=1
  int w [3] = '{8, 5, 8};
  int n [3] = '{4, 4, 1};
  int tot [3];
  int cnt [3];
  bit dn  [3];

  adder_result_accumulator_if #(.ACC_W(8), .COUNT_N(4)) ifa ();
  adder_result_accumulator_if #(.ACC_W(5), .COUNT_N(4)) ifb ();
  adder_result_accumulator_if #(.ACC_W(8), .COUNT_N(1)) ifc ();

  assign ifa.In_valid = in_valid;
  assign ifa.Sum = v[3:0];
  assign ifa.Cout = v[4];
  assign ifa.Out_ready = out_ready;
  assign ifb.In_valid = in_valid;
  assign ifb.Sum = v[3:0];
  assign ifb.Cout = v[4];
  assign ifb.Out_ready = out_ready;
  assign ifc.In_valid = in_valid;
  assign ifc.Sum = v[3:0];
  assign ifc.Cout = v[4];
  assign ifc.Out_ready = out_ready;

  adder_result_accumulator #(.ACC_W(8), .COUNT_N(4)) dut_a (.clk(clk), .rst(rst), .Clear(clear), .bus(ifa));
  adder_result_accumulator #(.ACC_W(5), .COUNT_N(4)) dut_b (.clk(clk), .rst(rst), .Clear(clear), .bus(ifb));
  adder_result_accumulator #(.ACC_W(8), .COUNT_N(1)) dut_c (.clk(clk), .rst(rst), .Clear(clear), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_acc(input int i);
    int mx;
    mx = (1 << w[i]) - 1;
`ifdef ADD_ACC_SAT_EN
    return (tot[i] > mx) ? mx : tot[i];
`else
    return tot[i] % (mx + 1);
`endif
  endfunction

  task automatic cmp_inst(input int i, input logic rdy, input logic vld,
                          input logic [7:0] acc, input logic ovf, input logic [2:0] count);
    chk($sformatf("i%0d in_ready", i), 32'(rdy), dn[i] ? 0 : 1);
    chk($sformatf("i%0d out_valid", i), 32'(vld), dn[i] ? 1 : 0);
    chk($sformatf("i%0d acc", i), 32'(acc), exp_acc(i));
    chk($sformatf("i%0d ovf", i), 32'(ovf), (tot[i] > (1 << w[i]) - 1) ? 1 : 0);
    chk($sformatf("i%0d count", i), 32'(count), cnt[i]);
  endtask

  // Model: a block is the list of accepted values; outputs follow from its total and length.
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst || clear) begin
          tot[i] = 0; cnt[i] = 0; dn[i] = 0;
        end else if (dn[i]) begin
          if (out_ready) begin
            tot[i] = 0; cnt[i] = 0; dn[i] = 0;
          end
        end else if (in_valid) begin
          tot[i] += int'(v);
          cnt[i]++;
          if (cnt[i] == n[i]) dn[i] = 1;
        end
      end
      #1;
      cmp_inst(0, ifa.In_ready, ifa.Out_valid, 8'(ifa.Acc), ifa.Ovf, 3'(ifa.Count));
      cmp_inst(1, ifb.In_ready, ifb.Out_valid, 8'(ifb.Acc), ifb.Ovf, 3'(ifb.Count));
      cmp_inst(2, ifc.In_ready, ifc.Out_valid, 8'(ifc.Acc), ifc.Ovf, 3'(ifc.Count));
    end
  end

  task automatic cyc(input logic iv, input logic [4:0] val, input logic ordy, input logic clr);
    in_valid  = iv;
    v         = val;
    out_ready = ordy;
    clear     = clr;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; v = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 32'(ifa.In_ready), 1);
    chk("reset out_valid", 32'(ifa.Out_valid), 0);
    chk("reset acc", 32'(ifa.Acc), 0);
    chk("reset count", 32'(ifa.Count), 0);
    rst = 1'b0;

    // Normal block: 8+7+15+17
    cyc(1, 5'd8, 1, 0); cyc(1, 5'd7, 1, 0); cyc(1, 5'd15, 1, 0); cyc(1, 5'd17, 1, 0);
    chk("normal out_valid", 32'(ifa.Out_valid), 1);
    chk("normal acc", 32'(ifa.Acc), 47);
    chk("normal ovf", 32'(ifa.Ovf), 0);
    cyc(0, 5'd0, 1, 0);
    chk("normal one-cycle valid", 32'(ifa.Out_valid), 0);
    chk("normal next clean", 32'(ifa.Acc), 0);

    // Overflow on ACC_W=5
    cyc(1, 5'd31, 1, 0); cyc(1, 5'd31, 1, 0); cyc(1, 5'd31, 1, 0); cyc(1, 5'd31, 1, 0);
    chk("ovf out_valid", 32'(ifb.Out_valid), 1);
`ifdef ADD_ACC_SAT_EN
    chk("ovf acc sat", 32'(ifb.Acc), 31);
`else
    chk("ovf acc wrap", 32'(ifb.Acc), 28);
`endif
    chk("ovf flag", 32'(ifb.Ovf), 1);
    chk("ovf wide acc", 32'(ifa.Acc), 124);
    cyc(0, 5'd0, 1, 0);

    // Backpressure
    cyc(1, 5'd1, 0, 0); cyc(1, 5'd2, 0, 0); cyc(1, 5'd3, 0, 0); cyc(1, 5'd4, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 5'd9, 0, 0);
      chk("bp in_ready", 32'(ifa.In_ready), 0);
      chk("bp acc", 32'(ifa.Acc), 10);
      chk("bp count", 32'(ifa.Count), 4);
      chk("bp out_valid", 32'(ifa.Out_valid), 1);
    end
    cyc(1, 5'd9, 1, 0);
    chk("bp handshake idle", 32'(ifa.Count), 0);
    cyc(1, 5'd9, 0, 0);
    chk("bp first acc", 32'(ifa.Acc), 9);
    chk("bp first count", 32'(ifa.Count), 1);

    // Clear mid-block
    cyc(0, 5'd0, 0, 1);
    cyc(1, 5'd8, 0, 0); cyc(1, 5'd7, 0, 0);
    cyc(1, 5'd15, 0, 1);
    chk("clear acc", 32'(ifa.Acc), 0);
    chk("clear count", 32'(ifa.Count), 0);
    cyc(1, 5'd3, 0, 0); cyc(1, 5'd5, 0, 0); cyc(1, 5'd6, 0, 0); cyc(1, 5'd10, 0, 0);
    chk("clear new total", 32'(ifa.Acc), 24);
    chk("clear new valid", 32'(ifa.Out_valid), 1);
    cyc(0, 5'd0, 1, 0);

    // Reset mid-block
    cyc(1, 5'd8, 1, 0); cyc(1, 5'd7, 1, 0);
    rst = 1'b1;
    cyc(1, 5'd15, 1, 0);
    rst = 1'b0;
    chk("rst mid out_valid", 32'(ifa.Out_valid), 0);
    chk("rst mid acc", 32'(ifa.Acc), 0);
    chk("rst mid count", 32'(ifa.Count), 0);
    chk("rst mid in_ready", 32'(ifa.In_ready), 1);

    // Reset in DONE
    cyc(1, 5'd20, 0, 0); cyc(1, 5'd20, 0, 0); cyc(1, 5'd20, 0, 0); cyc(1, 5'd20, 0, 0);
    chk("rst done pre valid", 32'(ifa.Out_valid), 1);
    chk("rst done pre acc", 32'(ifa.Acc), 80);
    chk("rst done pre ovf b", 32'(ifb.Ovf), 1);
    rst = 1'b1;
    cyc(1, 5'd5, 1, 0);
    rst = 1'b0;
    chk("rst done valid", 32'(ifa.Out_valid), 0);
    chk("rst done acc", 32'(ifa.Acc), 0);
    chk("rst done ovf b", 32'(ifb.Ovf), 0);

    // COUNT_N=1: alternate accept / handshake
    cyc(0, 5'd0, 0, 1);
    cyc(1, 5'd21, 1, 0);
    chk("n1 valid", 32'(ifc.Out_valid), 1);
    chk("n1 acc", 32'(ifc.Acc), 21);
    cyc(1, 5'd6, 1, 0);
    chk("n1 handshake", 32'(ifc.Out_valid), 0);
    cyc(1, 5'd6, 1, 0);
    chk("n1 second valid", 32'(ifc.Out_valid), 1);
    chk("n1 second acc", 32'(ifc.Acc), 6);
    cyc(0, 5'd0, 1, 0);
    chk("n1 second done", 32'(ifc.Out_valid), 0);

    cyc(0, 5'd0, 0, 0);
    cyc(0, 5'd0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
